// File: rtl/multicycle_control.sv
// Multicycle datapath controller: a Moore FSM that sequences fetch, decode,
// execute, memory and write-back steps, and counts retired instructions.
module multicycle_control (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        alu_zero,
  input  logic        mem_ready,
  output logic [3:0]  alu_op,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  pc_src,
  output logic        pc_write,
  output logic        ir_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        iord,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        illegal,
  output logic [3:0]  state,
  output logic [31:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_R_WB     = 4'd7,
    S_EXEC_I   = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_ILLEGAL  = 4'd12
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_NOT = 4'b0100;
  localparam logic [3:0] ALU_SRA = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_SRL = 4'b1010;
  localparam logic [3:0] ALU_ROL = 4'b1100;
  localparam logic [3:0] ALU_ROR = 4'b1101;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  function automatic logic funct_legal(input logic [5:0] f);
    case (f)
      6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111,
      6'b000011, 6'b000000, 6'b000010, 6'b000100, 6'b000110: funct_legal = 1'b1;
      default: funct_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] funct_alu_op(input logic [5:0] f);
    case (f)
      6'b100000: funct_alu_op = ALU_ADD;
      6'b100010: funct_alu_op = ALU_SUB;
      6'b100100: funct_alu_op = ALU_AND;
      6'b100101: funct_alu_op = ALU_OR;
      6'b100111: funct_alu_op = ALU_NOT;
      6'b000011: funct_alu_op = ALU_SRA;
      6'b000000: funct_alu_op = ALU_SLL;
      6'b000010: funct_alu_op = ALU_SRL;
      6'b000100: funct_alu_op = ALU_ROL;
      6'b000110: funct_alu_op = ALU_ROR;
      default:   funct_alu_op = ALU_ADD;
    endcase
  endfunction

  state_t      state_r;
  state_t      state_next_s;
  logic [31:0] instr_count_r;
  logic [3:0]  alu_op_hold_r;
  logic [3:0]  alu_op_s;
  logic        count_inc_s;
  logic        pc_write_s;
  logic        ir_write_s;
  logic        mem_write_s;
  logic        reg_write_s;
  logic        illegal_s;

  // Next-state and control decode; every output defaults to inactive.
  always_comb begin
    state_next_s = S_FETCH;
    alu_op_s     = ALU_ADD;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'b00;
    pc_src       = 2'b00;
    pc_write_s   = 1'b0;
    ir_write_s   = 1'b0;
    mem_read     = 1'b0;
    mem_write_s  = 1'b0;
    iord         = 1'b0;
    reg_write_s  = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    illegal_s    = 1'b0;
    count_inc_s  = 1'b0;
    case (state_r)
      S_FETCH: begin
        mem_read     = 1'b1;
        alu_src_b    = 2'b01;
        ir_write_s   = mem_ready;
        pc_write_s   = mem_ready;
        state_next_s = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_RTYPE:                state_next_s = funct_legal(funct) ? S_EXEC_R : S_ILLEGAL;
          OP_ADDI, OP_ANDI, OP_ORI: state_next_s = S_EXEC_I;
          OP_LW, OP_SW:            state_next_s = S_MEM_ADDR;
          OP_BEQ:                  state_next_s = S_BRANCH;
          OP_J:                    state_next_s = S_JUMP;
          default:                 state_next_s = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        // The opcode is re-read here; anything but lw/sw is treated as illegal.
        case (opcode)
          OP_LW:   state_next_s = S_MEM_RD;
          OP_SW:   state_next_s = S_MEM_WR;
          default: state_next_s = S_ILLEGAL;
        endcase
      end
      S_MEM_RD: begin
        mem_read     = 1'b1;
        iord         = 1'b1;
        state_next_s = mem_ready ? S_MEM_WB : S_MEM_RD;
      end
      S_MEM_WB: begin
        reg_write_s = 1'b1;
        mem_to_reg  = 1'b1;
        count_inc_s = 1'b1;
      end
      S_MEM_WR: begin
        mem_write_s  = 1'b1;
        iord         = 1'b1;
        count_inc_s  = mem_ready;
        state_next_s = mem_ready ? S_FETCH : S_MEM_WR;
      end
      S_EXEC_R: begin
        alu_src_a    = 1'b1;
        alu_op_s     = funct_alu_op(funct);
        state_next_s = S_R_WB;
      end
      S_R_WB: begin
        reg_write_s = 1'b1;
        reg_dst     = 1'b1;
        alu_op_s    = alu_op_hold_r;
        count_inc_s = 1'b1;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        case (opcode)
          OP_ANDI: alu_op_s = ALU_AND;
          OP_ORI:  alu_op_s = ALU_OR;
          default: alu_op_s = ALU_ADD;
        endcase
        state_next_s = S_I_WB;
      end
      S_I_WB: begin
        reg_write_s = 1'b1;
        alu_op_s    = alu_op_hold_r;
        count_inc_s = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_op_s    = ALU_SUB;
        pc_src      = 2'b01;
        pc_write_s  = alu_zero;
        count_inc_s = 1'b1;
      end
      S_JUMP: begin
        pc_src      = 2'b10;
        pc_write_s  = 1'b1;
        count_inc_s = 1'b1;
      end
      S_ILLEGAL: begin
        illegal_s = 1'b1;
      end
      default: begin
        state_next_s = S_FETCH;
      end
    endcase
  end

  // State, retired-instruction counter and the ALU op carried into write-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= S_FETCH;
      instr_count_r <= 32'd0;
      alu_op_hold_r <= ALU_ADD;
    end else begin
      state_r       <= state_next_s;
      instr_count_r <= count_inc_s ? (instr_count_r + 32'd1) : instr_count_r;
      if ((state_r == S_EXEC_R) || (state_r == S_EXEC_I)) begin
        alu_op_hold_r <= alu_op_s;
      end else begin
        alu_op_hold_r <= alu_op_hold_r;
      end
    end
  end

  // Side-effecting strobes are suppressed while reset is held.
  assign pc_write    = pc_write_s  & ~rst;
  assign ir_write    = ir_write_s  & ~rst;
  assign mem_write   = mem_write_s & ~rst;
  assign reg_write   = reg_write_s & ~rst;
  assign illegal     = illegal_s   & ~rst;
  assign alu_op      = alu_op_s;
  assign state       = state_r;
  assign instr_count = instr_count_r;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: stimulus pushes hand-computed
// per-cycle expectations, a negedge monitor pops and compares them.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  opcode = 6'd0;
  logic [5:0]  funct = 6'd0;
  logic        alu_zero = 1'b0;
  logic        mem_ready = 1'b1;
  logic [3:0]  alu_op;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  pc_src;
  logic        pc_write, ir_write, mem_read, mem_write, iord;
  logic        reg_write, reg_dst, mem_to_reg, illegal;
  logic [3:0]  state;
  logic [31:0] instr_count;

  multicycle_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
    .alu_zero(alu_zero), .mem_ready(mem_ready), .alu_op(alu_op),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
    .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read),
    .mem_write(mem_write), .iord(iord), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .illegal(illegal),
    .state(state), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // ctl bits: {asa, asb[1:0], pcs[1:0], pcw, irw, mr, mw, iord, rw, rd, m2r, ill}
  localparam logic [13:0] C_F_RDY  = 14'b0_01_00_1_1_1_0_0_0_0_0_0;
  localparam logic [13:0] C_F_WAIT = 14'b0_01_00_0_0_1_0_0_0_0_0_0;
  localparam logic [13:0] C_DEC    = 14'b0_11_00_0_0_0_0_0_0_0_0_0;
  localparam logic [13:0] C_MADDR  = 14'b1_10_00_0_0_0_0_0_0_0_0_0;
  localparam logic [13:0] C_MRD    = 14'b0_00_00_0_0_1_0_1_0_0_0_0;
  localparam logic [13:0] C_MWB    = 14'b0_00_00_0_0_0_0_0_1_0_1_0;
  localparam logic [13:0] C_MWR    = 14'b0_00_00_0_0_0_1_1_0_0_0_0;
  localparam logic [13:0] C_MWR_RS = 14'b0_00_00_0_0_0_0_1_0_0_0_0;
  localparam logic [13:0] C_EXR    = 14'b1_00_00_0_0_0_0_0_0_0_0_0;
  localparam logic [13:0] C_RWB    = 14'b0_00_00_0_0_0_0_0_1_1_0_0;
  localparam logic [13:0] C_EXI    = 14'b1_10_00_0_0_0_0_0_0_0_0_0;
  localparam logic [13:0] C_IWB    = 14'b0_00_00_0_0_0_0_0_1_0_0_0;
  localparam logic [13:0] C_BR1    = 14'b1_00_01_1_0_0_0_0_0_0_0_0;
  localparam logic [13:0] C_BR0    = 14'b1_00_01_0_0_0_0_0_0_0_0_0;
  localparam logic [13:0] C_JMP    = 14'b0_00_10_1_0_0_0_0_0_0_0_0;
  localparam logic [13:0] C_ILL    = 14'b0_00_00_0_0_0_0_0_0_0_0_1;

  typedef struct packed {
    logic [3:0]  st;
    logic [3:0]  aop;
    logic [13:0] ctl;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   n_cycle = 0;

  task automatic cyc(input logic r, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input logic rdy, input logic [3:0] st,
                     input logic [3:0] aop, input logic [13:0] ctl,
                     input logic [31:0] cnt);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; opcode = op; funct = fn; alu_zero = z; mem_ready = rdy;
    e.st = st; e.aop = aop; e.ctl = ctl; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) begin
      n_pass++;
    end else begin
      $display("FAIL %s cycle %0d: got %h, expected %h", name, n_cycle, act, req);
    end
  endtask

  // Monitor: every cycle with a pending expectation is compared mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    logic [13:0] ctl_act;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      ctl_act = {alu_src_a, alu_src_b, pc_src, pc_write, ir_write, mem_read,
                 mem_write, iord, reg_write, reg_dst, mem_to_reg, illegal};
      check("state", {28'd0, state}, {28'd0, e.st});
      check("alu_op", {28'd0, alu_op}, {28'd0, e.aop});
      check("ctl", {18'd0, ctl_act}, {18'd0, e.ctl});
      check("instr_count", instr_count, e.cnt);
      n_cycle++;
    end
  end

  initial begin
    int wait_cycles;
    repeat (2) @(posedge clk);
    // Reset held: FETCH, count 0, pc_write/ir_write suppressed
    cyc(1'b1, 6'b000000, 6'b100000, 1'b0, 1'b1, 4'd0, 4'b0000, C_F_WAIT, 32'd0);
    // add
    cyc(1'b0, 6'b000000, 6'b100000, 1'b0, 1'b1, 4'd0, 4'b0000, C_F_RDY, 32'd0);
    cyc(1'b0, 6'b000000, 6'b100000, 1'b0, 1'b1, 4'd1, 4'b0000, C_DEC,   32'd0);
    cyc(1'b0, 6'b000000, 6'b100000, 1'b0, 1'b1, 4'd6, 4'b0000, C_EXR,   32'd0);
    cyc(1'b0, 6'b000000, 6'b100000, 1'b0, 1'b1, 4'd7, 4'b0000, C_RWB,   32'd0);
    // ror, funct changed during R_WB must not alter alu_op
    cyc(1'b0, 6'b000000, 6'b000110, 1'b0, 1'b1, 4'd0, 4'b0000, C_F_RDY, 32'd1);
    cyc(1'b0, 6'b000000, 6'b000110, 1'b0, 1'b1, 4'd1, 4'b0000, C_DEC,   32'd1);
    cyc(1'b0, 6'b000000, 6'b000110, 1'b0, 1'b1, 4'd6, 4'b1101, C_EXR,   32'd1);
    cyc(1'b0, 6'b000000, 6'b100000, 1'b0, 1'b1, 4'd7, 4'b1101, C_RWB,   32'd1);
    // lw with two wait cycles in MEM_RD; opcode noise there is ignored
    cyc(1'b0, 6'b100011, 6'b000000, 1'b0, 1'b1, 4'd0, 4'b0000, C_F_RDY, 32'd2);
    cyc(1'b0, 6'b100011, 6'b000000, 1'b0, 1'b1, 4'd1, 4'b0000, C_DEC,   32'd2);
    cyc(1'b0, 6'b100011, 6'b000000, 1'b0, 1'b1, 4'd2, 4'b0000, C_MADDR, 32'd2);
    cyc(1'b0, 6'b101011, 6'b000000, 1'b0, 1'b0, 4'd3, 4'b0000, C_MRD,   32'd2);
    cyc(1'b0, 6'b101011, 6'b000000, 1'b0, 1'b0, 4'd3, 4'b0000, C_MRD,   32'd2);
    cyc(1'b0, 6'b101011, 6'b000000, 1'b0, 1'b1, 4'd3, 4'b0000, C_MRD,   32'd2);
    cyc(1'b0, 6'b101011, 6'b000000, 1'b0, 1'b1, 4'd4, 4'b0000, C_MWB,   32'd2);
    // sw with one FETCH wait cycle
    cyc(1'b0, 6'b101011, 6'b000000, 1'b0, 1'b0, 4'd0, 4'b0000, C_F_WAIT, 32'd3);
    cyc(1'b0, 6'b101011, 6'b000000, 1'b0, 1'b1, 4'd0, 4'b0000, C_F_RDY, 32'd3);
    cyc(1'b0, 6'b101011, 6'b000000, 1'b0, 1'b1, 4'd1, 4'b0000, C_DEC,   32'd3);
    cyc(1'b0, 6'b101011, 6'b000000, 1'b0, 1'b1, 4'd2, 4'b0000, C_MADDR, 32'd3);
    cyc(1'b0, 6'b101011, 6'b000000, 1'b0, 1'b1, 4'd5, 4'b0000, C_MWR,   32'd3);
    // andi, opcode changed during I_WB must not alter alu_op
    cyc(1'b0, 6'b001100, 6'b000000, 1'b0, 1'b1, 4'd0, 4'b0000, C_F_RDY, 32'd4);
    cyc(1'b0, 6'b001100, 6'b000000, 1'b0, 1'b1, 4'd1, 4'b0000, C_DEC,   32'd4);
    cyc(1'b0, 6'b001100, 6'b000000, 1'b0, 1'b1, 4'd8, 4'b0010, C_EXI,   32'd4);
    cyc(1'b0, 6'b001101, 6'b000000, 1'b0, 1'b1, 4'd9, 4'b0010, C_IWB,   32'd4);
    // beq taken, then not taken
    cyc(1'b0, 6'b000100, 6'b000000, 1'b1, 1'b1, 4'd0, 4'b0000, C_F_RDY, 32'd5);
    cyc(1'b0, 6'b000100, 6'b000000, 1'b1, 1'b1, 4'd1, 4'b0000, C_DEC,   32'd5);
    cyc(1'b0, 6'b000100, 6'b000000, 1'b1, 1'b1, 4'd10, 4'b0001, C_BR1,  32'd5);
    cyc(1'b0, 6'b000100, 6'b000000, 1'b0, 1'b1, 4'd0, 4'b0000, C_F_RDY, 32'd6);
    cyc(1'b0, 6'b000100, 6'b000000, 1'b0, 1'b1, 4'd1, 4'b0000, C_DEC,   32'd6);
    cyc(1'b0, 6'b000100, 6'b000000, 1'b0, 1'b1, 4'd10, 4'b0001, C_BR0,  32'd6);
    // illegal opcode, then illegal R-type funct: count stays 7
    cyc(1'b0, 6'b111111, 6'b000000, 1'b0, 1'b1, 4'd0, 4'b0000, C_F_RDY, 32'd7);
    cyc(1'b0, 6'b111111, 6'b000000, 1'b0, 1'b1, 4'd1, 4'b0000, C_DEC,   32'd7);
    cyc(1'b0, 6'b000000, 6'b111111, 1'b0, 1'b1, 4'd12, 4'b0000, C_ILL,  32'd7);
    cyc(1'b0, 6'b000000, 6'b111111, 1'b0, 1'b1, 4'd0, 4'b0000, C_F_RDY, 32'd7);
    cyc(1'b0, 6'b000000, 6'b111111, 1'b0, 1'b1, 4'd1, 4'b0000, C_DEC,   32'd7);
    cyc(1'b0, 6'b000000, 6'b111111, 1'b0, 1'b1, 4'd12, 4'b0000, C_ILL,  32'd7);
    // sw stalled in MEM_WR, reset asserted during the stall
    cyc(1'b0, 6'b101011, 6'b000000, 1'b0, 1'b1, 4'd0, 4'b0000, C_F_RDY, 32'd7);
    cyc(1'b0, 6'b101011, 6'b000000, 1'b0, 1'b1, 4'd1, 4'b0000, C_DEC,   32'd7);
    cyc(1'b0, 6'b101011, 6'b000000, 1'b0, 1'b0, 4'd2, 4'b0000, C_MADDR, 32'd7);
    cyc(1'b0, 6'b101011, 6'b000000, 1'b0, 1'b0, 4'd5, 4'b0000, C_MWR,   32'd7);
    cyc(1'b1, 6'b101011, 6'b000000, 1'b0, 1'b0, 4'd5, 4'b0000, C_MWR_RS, 32'd7);
    cyc(1'b0, 6'b000010, 6'b000000, 1'b0, 1'b0, 4'd0, 4'b0000, C_F_WAIT, 32'd0);
    // counter preset to all-ones, then j wraps it to zero
    cyc(1'b0, 6'b000010, 6'b000000, 1'b0, 1'b0, 4'd0, 4'b0000, C_F_WAIT, 32'hFFFFFFFF);
    force dut.instr_count_r = 32'hFFFFFFFF;
    cyc(1'b0, 6'b000010, 6'b000000, 1'b0, 1'b1, 4'd0, 4'b0000, C_F_RDY, 32'hFFFFFFFF);
    release dut.instr_count_r;
    cyc(1'b0, 6'b000010, 6'b000000, 1'b0, 1'b1, 4'd1, 4'b0000, C_DEC,   32'hFFFFFFFF);
    cyc(1'b0, 6'b000010, 6'b000000, 1'b0, 1'b1, 4'd11, 4'b0000, C_JMP,  32'hFFFFFFFF);
    cyc(1'b0, 6'b000010, 6'b000000, 1'b0, 1'b0, 4'd0, 4'b0000, C_F_WAIT, 32'd0);

    wait_cycles = 0;
    while ((exp_q.size() != 0) && (wait_cycles < 20)) begin
      @(posedge clk);
      wait_cycles++;
    end
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-002 The block SHALL have these inputs: opcode input 6, IR[31:26]; funct input 6, IR[5:0]; alu_zero input 1, ALU Zero flag; mem_ready input 1, memory access complete.
REQ-003 The block SHALL have these outputs: alu_op output 4 (ALU Op code); alu_src_a output 1 (0=PC, 1=regA); alu_src_b output 2 (00 regB, 01 const 4, 10 sign-ext imm, 11 imm<<2); pc_src output 2 (00 ALU, 01 ALUOut, 10 jump target); pc_write, ir_write, mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg, illegal output 1 each; state output 4; instr_count output 32.

Function
REQ-004 The ALU op encodings SHALL be: add 0000, sub 0001, and 0010, or 0011, not 0100, sra 1000, sll 1001, srl 1010, rol 1100, ror 1101.
REQ-005 Opcode classes SHALL be: 000000 R-type, 001000 addi, 001100 andi, 001101 ori, 100011 lw, 101011 sw, 000100 beq, 000010 j; any other opcode is illegal.
REQ-006 R-type funct mapping SHALL be: 100000 add, 100010 sub, 100100 and, 100101 or, 100111 not, 000011 sra, 000000 sll, 000010 srl, 000100 rol, 000110 ror; any other funct is illegal.
REQ-007 Control outputs SHALL be a Moore function of the state register, except pc_write in BRANCH and the mem_ready-qualified signals in FETCH. Every output not listed for a state SHALL be 0; alu_op defaults to 0000.
REQ-008 States, encodings and next-state behaviour SHALL be as follows:
- FETCH=0: mem_read=1, alu_src_b=01, add; ir_write=pc_write=mem_ready; stay until mem_ready=1, then DECODE.
- DECODE=1: alu_src_b=11, add. Next state: R-type with legal funct -> EXEC_R; addi/andi/ori -> EXEC_I; lw/sw -> MEM_ADDR; beq -> BRANCH; j -> JUMP; else -> ILLEGAL.
- MEM_ADDR=2: alu_src_a=1, alu_src_b=10, add. Next: lw -> MEM_RD; sw -> MEM_WR.
- MEM_RD=3: mem_read=1, iord=1; wait for mem_ready, then MEM_WB.
- MEM_WB=4: reg_write=1, mem_to_reg=1; next FETCH.
- MEM_WR=5: mem_write=1, iord=1; wait for mem_ready, then FETCH.
- EXEC_R=6: alu_src_a=1, alu_src_b=00, alu_op per REQ-006; next R_WB.
- R_WB=7: reg_write=1, reg_dst=1; alu_op held from EXEC_R; next FETCH.
- EXEC_I=8: alu_src_a=1, alu_src_b=10, alu_op add/and/or per opcode; next I_WB.
- I_WB=9: reg_write=1, reg_dst=0; alu_op held from EXEC_I; next FETCH.
- BRANCH=10: alu_src_a=1, alu_src_b=00, sub, pc_src=01, pc_write=alu_zero; next FETCH.
- JUMP=11: pc_src=10, pc_write=1; next FETCH.
- ILLEGAL=12: illegal=1 for exactly one cycle; next FETCH.
REQ-009 Encodings 13-15 SHALL drive all outputs to 0 and go to FETCH on the next edge.
REQ-010 opcode and funct SHALL be sampled only in DECODE, MEM_ADDR, EXEC_R and EXEC_I; changes to them in any other state SHALL have no effect.
REQ-011 An instruction SHALL take 3 cycles (j, beq, illegal), 4 cycles (R, I, sw) or 5 cycles (lw), plus one extra cycle per mem_ready=0 cycle in FETCH, MEM_RD or MEM_WR.
REQ-012 instr_count SHALL increment by 1 on each transition into FETCH from MEM_WB, MEM_WR, R_WB, I_WB, BRANCH or JUMP; it SHALL NOT increment from ILLEGAL or from encodings 13-15; it wraps from 0xFFFFFFFF to 0.
REQ-013 The state output SHALL equal the state register.

Reset
REQ-014 When rst=1 at a rising edge, the state SHALL become FETCH and instr_count SHALL become 0, regardless of the current state, including a pending mem_ready wait.
REQ-015 While rst=1, pc_write, ir_write, mem_write, reg_write and illegal SHALL be forced to 0.
REQ-016 The first FETCH after rst is released SHALL behave per REQ-008.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- add (opcode 000000, funct 100000), mem_ready=1 -> states 0,1,6,7,0; alu_op=0000 in 6 and 7; reg_write=1 and reg_dst=1 only in 7; instr_count 0->1.
- lw (100011), mem_ready low 2 cycles in MEM_RD -> states 0,1,2,3,3,3,4,0; iord=1 in state 3; mem_to_reg=1 in state 4.
- beq (000100) with alu_zero=1, then again with alu_zero=0 -> pc_write=1 in BRANCH for the first, 0 for the second; pc_src=01; alu_op=0001; count +1 each.
- opcode 111111, then R-type funct 111111 -> ILLEGAL each time; illegal=1 for one cycle; instr_count unchanged.
- rst=1 asserted in MEM_WR with mem_ready=0 -> next state 0; instr_count=0; mem_write=0 while rst=1.
- 2^32-1 increments (or force) reaching instr_count=0xFFFFFFFF, then a j (000010) -> instr_count=0; pc_write=1 and pc_src=10 in JUMP.
